display_timing_ctrl: RTL and testbench

DISPLAY_TIMING_CTRL -- requirements
Module: display_timing_ctrl

---
 rtl/display_timing_ctrl.sv | 157 +++++++++++++++
 tb/tb_display_timing_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/display_timing_ctrl.sv
`default_nettype none
// ==== display_timing_ctrl : raster timing generator with shadowed frame base and per-line fetch requests ====
// ==== Rev 1.0 ====
module display_timing_ctrl #(
  parameter int          H_ACTIVE    = 640,
  parameter int          H_FP        = 16,
  parameter int          H_SYNC      = 96,
  parameter int          H_BP        = 48,
  parameter int          V_ACTIVE    = 480,
  parameter int          V_FP        = 10,
  parameter int          V_SYNC      = 2,
  parameter int          V_BP        = 33,
  parameter logic [29:0] LINE_STRIDE = 30'd640
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CLRVBLNK,
  input  logic [29:0] DISPADDR,
  input  logic        DISPON,
  output logic        VBLANK,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        DE,
  output logic        FETCH_REQ,
  output logic [29:0] FETCH_ADDR,
  output logic [9:0]  FETCH_LINE,
  input  logic        FETCH_ACK,
  output logic        SCAN_ON,
  output logic        UNDERRUN
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT        = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT        = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic          vblank_q, vblank_d;
  logic          scan_on_q, scan_on_d;
  logic [29:0]   acc_q, acc_d;
  logic          fetch_req_q, fetch_req_d;
  logic [29:0]   fetch_addr_q, fetch_addr_d;
  logic [9:0]    fetch_line_q, fetch_line_d;
  logic          underrun_q, underrun_d;

  logic          h_wrap;
  logic [VW-1:0] next_line;
  logic          vblank_evt;
  logic          line_pt;
  logic          fetch_pt;

  always_comb begin
    h_wrap     = (hcnt_q == H_LAST);
    next_line  = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
    vblank_evt = (hcnt_q == '0) && (vcnt_q == V_ACT);
    line_pt    = (hcnt_q == H_ACT) && (next_line < V_ACT);
    fetch_pt   = line_pt && scan_on_q;
  end

  always_comb begin
    hcnt_d       = h_wrap ? '0 : hcnt_q + 1'b1;
    vcnt_d       = h_wrap ? next_line : vcnt_q;
    hsync_d      = !((hcnt_q >= H_SYNC_START) && (hcnt_q < H_SYNC_END));
    vsync_d      = !((vcnt_q >= V_SYNC_START) && (vcnt_q < V_SYNC_END));
    de_d         = (hcnt_q < H_ACT) && (vcnt_q < V_ACT) && scan_on_q;
    vblank_d     = vblank_q;
    scan_on_d    = scan_on_q;
    acc_d        = acc_q;
    fetch_req_d  = fetch_req_q;
    fetch_addr_d = fetch_addr_q;
    fetch_line_d = fetch_line_q;
    underrun_d   = underrun_q;

    // Set takes priority over a same-cycle clear.
    if (vblank_evt) begin
      vblank_d = 1'b1;
    end else if (CLRVBLNK) begin
      vblank_d = 1'b0;
    end

    // The accumulator holds the address of the next line to fetch; it is
    // reloaded from the new base at vblank, so line 0 gets the base exactly.
    if (vblank_evt) begin
      scan_on_d = DISPON;
      acc_d     = DISPADDR;
    end else if (line_pt) begin
      acc_d = acc_q + LINE_STRIDE;
    end

    if (fetch_req_q && FETCH_ACK) begin
      fetch_req_d = 1'b0;
    end
    if (fetch_pt) begin
      if (fetch_req_q && !FETCH_ACK) begin
        underrun_d = 1'b1;
      end
      fetch_req_d  = 1'b1;
      fetch_addr_d = acc_q;
      fetch_line_d = 10'(next_line);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      de_q         <= 1'b0;
      vblank_q     <= 1'b0;
      scan_on_q    <= 1'b0;
      acc_q        <= '0;
      fetch_req_q  <= 1'b0;
      fetch_addr_q <= '0;
      fetch_line_q <= '0;
      underrun_q   <= 1'b0;
    end else begin
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      de_q         <= de_d;
      vblank_q     <= vblank_d;
      scan_on_q    <= scan_on_d;
      acc_q        <= acc_d;
      fetch_req_q  <= fetch_req_d;
      fetch_addr_q <= fetch_addr_d;
      fetch_line_q <= fetch_line_d;
      underrun_q   <= underrun_d;
    end
  end

  assign VBLANK     = vblank_q;
  assign HSYNC      = hsync_q;
  assign VSYNC      = vsync_q;
  assign DE         = de_q;
  assign SCAN_ON    = scan_on_q;
  assign FETCH_REQ  = fetch_req_q;
  assign FETCH_ADDR = fetch_addr_q;
  assign FETCH_LINE = fetch_line_q;
  assign UNDERRUN   = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_display_timing_ctrl.sv
`default_nettype none
// ==== tb_display_timing_ctrl : scoreboard bench for display_timing_ctrl on a 14x7 raster ====
// ==== Rev 1.0 ====
module tb_display_timing_ctrl;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int STRIDE = 16;
  localparam logic [46:0] RST_VEC = {7'b0110000, 10'd0, 30'd0};

  logic        clk = 1'b0;
  logic        rst;
  logic        CLRVBLNK;
  logic [29:0] DISPADDR;
  logic        DISPON;
  logic        FETCH_ACK;
  logic        VBLANK, HSYNC, VSYNC, DE, FETCH_REQ, SCAN_ON, UNDERRUN;
  logic [29:0] FETCH_ADDR;
  logic [9:0]  FETCH_LINE;

  int n_checks = 0;
  int n_errors = 0;
  int cyc, wcnt, de0, de2, req0;
  bit ack_on;

  // reference model state
  int          m_h, m_v;
  logic        m_vb, m_hs, m_vs, m_de, m_req, m_en, m_und, m_issued;
  logic [29:0] m_addr, m_base;
  logic [9:0]  m_line;
  logic [46:0] exp_q[$];

  always #5 clk = ~clk;

  display_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .LINE_STRIDE(30'd16)
  ) dut (
    .clk(clk), .rst(rst), .CLRVBLNK(CLRVBLNK), .DISPADDR(DISPADDR), .DISPON(DISPON),
    .VBLANK(VBLANK), .HSYNC(HSYNC), .VSYNC(VSYNC), .DE(DE),
    .FETCH_REQ(FETCH_REQ), .FETCH_ADDR(FETCH_ADDR), .FETCH_LINE(FETCH_LINE),
    .FETCH_ACK(FETCH_ACK), .SCAN_ON(SCAN_ON), .UNDERRUN(UNDERRUN)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [46:0] dut_vec();
    return {VBLANK, HSYNC, VSYNC, DE, FETCH_REQ, SCAN_ON, UNDERRUN, FETCH_LINE, FETCH_ADDR};
  endfunction

  function automatic logic [46:0] model_vec();
    return {m_vb, m_hs, m_vs, m_de, m_req, m_en, m_und, m_line, m_addr};
  endfunction

  task automatic model_step(input logic r, input logic clr, input logic [29:0] da,
                            input logic on, input logic ack);
    int   nl;
    logic ev, fp, old_req;
    m_issued = 1'b0;
    if (!r) begin
      m_h = 0; m_v = 0; m_vb = 0; m_hs = 1; m_vs = 1; m_de = 0;
      m_req = 0; m_addr = '0; m_line = '0; m_en = 0; m_base = '0; m_und = 0;
    end else begin
      nl      = (m_v + 1) % VT;
      ev      = (m_h == 0) && (m_v == VA);
      fp      = (m_h == HA) && (nl < VA) && m_en;
      old_req = m_req;
      m_hs    = !((m_h >= HA + HF) && (m_h < HA + HF + HS));
      m_vs    = !((m_v >= VA + VF) && (m_v < VA + VF + VS));
      m_de    = (m_h < HA) && (m_v < VA) && m_en;
      if (fp) begin
        if (old_req && !ack) m_und = 1'b1;
        m_req    = 1'b1;
        m_line   = 10'(nl);
        m_addr   = m_base + 30'(nl * STRIDE);
        m_issued = 1'b1;
      end else if (old_req && ack) begin
        m_req = 1'b0;
      end
      if (ev) begin
        m_vb = 1'b1; m_base = da; m_en = on;
      end else if (clr) begin
        m_vb = 1'b0;
      end
      if (m_h == HT - 1) begin
        m_h = 0;
        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
    end
  endtask

  // Drive stimulus already set up, predict, advance one clock, compare.
  task automatic tick();
    model_step(rst, CLRVBLNK, DISPADDR, DISPON, FETCH_ACK);
    exp_q.push_back(model_vec());
    @(posedge clk);
    #1;
    chk("outputs", 64'(dut_vec()), 64'(exp_q.pop_front()));
    if (m_issued) wcnt = 1;
    else if (m_req) wcnt++;
    else wcnt = 0;
  endtask

  task automatic directed();
    if (cyc == 10) chk("hsync_before", 64'(HSYNC), 64'd1);
    if (cyc == 11 || cyc == 12) chk("hsync_low", 64'(HSYNC), 64'd0);
    if (cyc == 13) chk("hsync_after", 64'(HSYNC), 64'd1);
    if (cyc == 56) begin
      chk("vblank_pre_event", 64'(VBLANK), 64'd0);
      chk("scan_on_pre_event", 64'(SCAN_ON), 64'd0);
    end
    if (cyc == 57) begin
      chk("vblank_set", 64'(VBLANK), 64'd1);
      chk("scan_on_set", 64'(SCAN_ON), 64'd1);
    end
    if (cyc == 70) begin
      chk("vsync_before", 64'(VSYNC), 64'd1);
      chk("vblank_held", 64'(VBLANK), 64'd1);
    end
    if (cyc == 71) begin
      chk("vsync_low", 64'(VSYNC), 64'd0);
      chk("vblank_cleared", 64'(VBLANK), 64'd0);
    end
    if (cyc == 84) chk("vsync_low_end", 64'(VSYNC), 64'd0);
    if (cyc == 85) chk("vsync_after", 64'(VSYNC), 64'd1);
    if (cyc == 92) chk("no_early_fetch", 64'(req0), 64'd0);
    if (cyc == 98) chk("de_frame0_off", 64'(de0), 64'd0);
    if (cyc == 93 || cyc == 107 || cyc == 121 || cyc == 135) begin
      chk("fetch_req", 64'(FETCH_REQ), 64'd1);
      chk("fetch_addr", 64'(FETCH_ADDR), 64'h100 + 64'((cyc - 93) / 14 * 16));
      chk("fetch_line", 64'(FETCH_LINE), 64'((cyc - 93) / 14));
    end
    if (cyc == 140) chk("no_underrun_acked", 64'(UNDERRUN), 64'd0);
    if (cyc == 155) chk("vblank_set_wins", 64'(VBLANK), 64'd1);
    if (cyc == 191) begin
      chk("frame2_line0_addr", 64'(FETCH_ADDR), 64'h100);
      chk("frame2_line0_line", 64'(FETCH_LINE), 64'd0);
    end
    if (cyc == 204) chk("underrun_pre", 64'(UNDERRUN), 64'd0);
    if (cyc == 205) begin
      chk("underrun_set", 64'(UNDERRUN), 64'd1);
      chk("underrun_addr", 64'(FETCH_ADDR), 64'h110);
      chk("underrun_line", 64'(FETCH_LINE), 64'd1);
      chk("underrun_req", 64'(FETCH_REQ), 64'd1);
    end
    if (cyc == 218) chk("req_held", 64'(FETCH_REQ), 64'd1);
    if (cyc == 219) chk("old_base_line2", 64'(FETCH_ADDR), 64'h120);
    if (cyc == 233) chk("old_base_line3", 64'(FETCH_ADDR), 64'h130);
    if (cyc == 289) begin
      chk("new_base_line0", 64'(FETCH_ADDR), 64'h200);
      chk("new_base_line", 64'(FETCH_LINE), 64'd0);
    end
    if (cyc == 294) chk("de_frame2_count", 64'(de2), 64'd32);
    if (cyc == 296) begin
      chk("rst_mid_request", 64'(dut_vec()), 64'(RST_VEC));
      chk("rst_req_dropped", 64'(FETCH_REQ), 64'd0);
    end
  endtask

  initial begin
    rst = 1'b0; CLRVBLNK = 1'b0; DISPADDR = '0; DISPON = 1'b0; FETCH_ACK = 1'b0;
    cyc = 0; wcnt = 0; de0 = 0; de2 = 0; req0 = 0; ack_on = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("reset_state", 64'(dut_vec()), 64'(RST_VEC));

    rst = 1'b1;
    cyc = 0;
    while (cyc < 297) begin
      DISPON    = (cyc >= 20);
      DISPADDR  = (cyc >= 210) ? 30'h200 : ((cyc >= 20) ? 30'h100 : 30'h0);
      CLRVBLNK  = (cyc == 70) || (cyc == 154);
      rst       = !((cyc == 295) || (cyc == 296));
      ack_on    = (cyc < 150);
      FETCH_ACK = ack_on && m_req && (wcnt > 2);
      tick();
      cyc++;
      if (cyc >= 1 && cyc <= 98 && DE) de0++;
      if (cyc <= 92 && FETCH_REQ) req0++;
      if (cyc >= 197 && cyc <= 294 && DE) de2++;
      directed();
    end

    // Counting must restart from zero after the mid-request reset.
    rst = 1'b1; CLRVBLNK = 1'b0; FETCH_ACK = 1'b0;
    cyc = 0;
    while (cyc < 30) begin
      tick();
      cyc++;
      if (cyc == 10) chk("restart_hsync_high", 64'(HSYNC), 64'd1);
      if (cyc == 11) chk("restart_hsync_low", 64'(HSYNC), 64'd0);
      if (cyc == 20) chk("restart_scan_off", 64'(SCAN_ON), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
